neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage that computes one neuron's pre-activation sum: bias + Σ x[i]·w[i] over N_INPUTS beats.
- Sits directly upstream of the activation/prediction stage. Its registered `sum` output drives that stage's `sum` input.
- Inputs arrive as a valid/ready stream, one (x, w) pair per beat.
- The result is presented with a valid/ready output handshake. Arithmetic uses the shared sfp signed fixed-point type.

Parameters:
- N_INPUTS, 4: number of (x, w) beats per neuron evaluation; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a new evaluation. Sampled in IDLE, or in DONE on the same cycle as an output handshake.
- bias  in  sfp  bias term, sampled together with start.
- busy  out  1  high in ACCUM and DONE.
- in_valid  in  1  (x, w) beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- x  in  sfp  input activation.
- w  in  sfp  weight.
- out_valid  out  1  sum/overflow valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  sfp  saturated pre-activation sum.
- overflow  out  1  the result was clipped to SFP_MAX or SFP_MIN.

Behaviour:
- Width rules:
  - W = $bits(sfp); FRAC = fractional bits from FixedPoint.
  - Product = full 2W-bit signed x·w, then arithmetic right shift by FRAC (rounds toward −∞).
  - Accumulator width is ACC_W = 2W + $clog2(N_INPUTS+1), so no intermediate overflow is possible.
  - bias is sign-extended into the accumulator.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0, busy=0.
  - start=1: acc←bias, cnt←0, go to ACCUM.
- ACCUM:
  - in_ready=1; beats are accepted at one per cycle with no bubbles.
  - On an accepted beat: acc←acc+product, cnt←cnt+1.
  - An accepted beat with cnt==N_INPUTS-1 moves to DONE.
  - While in_valid=0, hold state and acc.
  - start is ignored.
- DONE:
  - Entered with sum and overflow registered on the transition: sum = saturate(final acc), overflow = (acc > SFP_MAX or acc < SFP_MIN).
  - out_valid=1; sum and overflow stay stable until the handshake.
  - On out_valid && out_ready:
    - start=1: reload acc←bias, cnt←0, go straight to ACCUM (back-to-back, no IDLE cycle).
    - otherwise go to IDLE.
  - start without out_ready is ignored.
- Latency:
  - First in_ready arrives 1 cycle after start.
  - out_valid arrives 1 cycle after the last accepted beat.
  - Minimum evaluation period is N_INPUTS+1 cycles.
- Reset:
  - state=IDLE, acc=0, cnt=0, sum=0, overflow=0, out_valid=0, in_ready=0, busy=0.
  - Reset in the middle of an evaluation discards the partial accumulation. There is no out_valid for the aborted evaluation.
- N_INPUTS=1: a single beat moves to DONE.
- Beats presented while not in ACCUM are not accepted; in_ready=0.
- x/w/in_valid are don't-care outside ACCUM.

Decomposition:
- FixedPoint package gets:
  - constants SFP_MAX and SFP_MIN;
  - function sfp_mul_full (2W signed product shifted by FRAC);
  - function sfp_saturate (wide accumulator → sfp plus clip flag).
- Common package gets:
  - enum mac_state_t {IDLE, ACCUM, DONE}.
- No sub-module. The datapath is the package functions plus one accumulator register and one counter.

Test Plan:
- Basic sum:
  - Stimulus: start with bias=0.5; beats x={1.0, 2.0, −1.0, 0.25}, w={0.5, 0.5, 1.0, 4.0}, presented back-to-back; out_ready=1.
  - Response: out_valid on the cycle after beat 4, sum=2.0, overflow=0, then return to IDLE.
- Input stall and output backpressure:
  - Stimulus: same data as Basic sum, with in_valid dropped for 3 cycles between beats 2 and 3; then out_ready held at 0 for 5 cycles.
  - Response: acc holds during the stall; sum=2.0 is stable and out_valid stays high throughout backpressure.
- Saturation:
  - Stimulus: bias=0; 4 beats of x=w=SFP_MAX.
  - Response: sum=SFP_MAX, overflow=1.
  - Stimulus: x=SFP_MAX, w=SFP_MIN for 4 beats.
  - Response: sum=SFP_MIN, overflow=1.
- Rounding:
  - Stimulus: bias=0; one beat x=−1 LSB, w=0.5 (other beats 0).
  - Response: sum=−1 LSB (floor), overflow=0.
- Back-to-back:
  - Stimulus: in DONE, assert out_ready and start together with bias=−1.0; 4 beats of zero product.
  - Response: no IDLE cycle; in_ready=1 on the next cycle; second result is sum=−1.0.
- Reset mid-evaluation:
  - Stimulus: assert rst after 2 accepted beats.
  - Response: next cycle state is IDLE, in_ready=0, out_valid=0, sum=0. A fresh start with bias=0.25 and zero beats yields sum=0.25.

Source files
------------

// File: rtl/neuron_mac_pkg.sv
// Shared fixed-point type, helpers and FSM state encoding for the neuron MAC stage.
package neuron_mac_pkg;

  localparam int unsigned SFP_W    = 16;
  localparam int unsigned SFP_FRAC = 8;
  localparam int unsigned SAT_IN_W = 64;

  typedef logic signed [SFP_W-1:0] sfp;

  localparam sfp SFP_MAX = 16'sh7FFF;
  localparam sfp SFP_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  typedef struct packed {
    sfp   val;
    logic clip;
  } sfp_sat_t;

  // Full-precision product rescaled to the sfp binary point; >>> floors toward -inf.
  function automatic logic signed [2*SFP_W-1:0] sfp_mul_full(input sfp a, input sfp b);
    logic signed [2*SFP_W-1:0] p;
    p = (2*SFP_W)'(a) * (2*SFP_W)'(b);
    return p >>> SFP_FRAC;
  endfunction

  function automatic sfp_sat_t sfp_saturate(input logic signed [SAT_IN_W-1:0] a);
    sfp_sat_t r;
    if (a > SAT_IN_W'(SFP_MAX)) begin
      r.val  = SFP_MAX;
      r.clip = 1'b1;
    end else if (a < SAT_IN_W'(SFP_MIN)) begin
      r.val  = SFP_MIN;
      r.clip = 1'b1;
    end else begin
      r.val  = a[SFP_W-1:0];
      r.clip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate: bias + sum of x*w over N_INPUTS streamed beats,
// saturated to sfp and offered on a valid/ready output.
module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int unsigned N_INPUTS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  sfp   bias,
  output logic busy,
  input  logic in_valid,
  output logic in_ready,
  input  sfp   x,
  input  sfp   w,
  output logic out_valid,
  input  logic out_ready,
  output sfp   sum,
  output logic overflow
);

  localparam int unsigned ACC_W = 2 * SFP_W + $clog2(N_INPUTS + 1);
  localparam int unsigned CNT_W = $clog2(N_INPUTS + 1);

  mac_state_t              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  sfp                      sum_q, sum_d;
  logic                    ovf_q, ovf_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;

  logic signed [2*SFP_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_next;
  sfp_sat_t                  sat;

  assign prod     = sfp_mul_full(x, w);
  assign acc_next = acc_q + ACC_W'(prod);
  assign sat      = sfp_saturate(SAT_IN_W'(acc_next));

  // Next-state, datapath update and registered handshake flags.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = ACC_W'(bias);
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
            sum_d   = sat.val;
            ovf_d   = sat.clip;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            acc_d   = ACC_W'(bias);
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed cases plus randomized evaluations
// against an integer reference model.
module tb_neuron_mac;
  import neuron_mac_pkg::*;

  localparam int N   = 4;
  localparam int ONE = 256;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic busy, in_ready, out_valid, overflow;
  sfp   bias, x, w, sum;

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   bx[N];
  int   bw[N];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: exact integer sum of floored products, then clamp to 16-bit signed.
  function automatic exp_t model(input int b);
    exp_t   e;
    longint acc;
    acc = b;
    for (int i = 0; i < N; i++) acc += floor_div(longint'(bx[i]) * longint'(bw[i]), ONE);
    e.ovf = (acc > 32767) || (acc < -32768);
    if (acc > 32767)       e.sum = 32767;
    else if (acc < -32768) e.sum = -32768;
    else                   e.sum = int'(acc);
    return e;
  endfunction

  // Monitor: pops on every output handshake; checks hold value while backpressured.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("sum", longint'(sum), longint'(e.sum));
        chk("overflow", longint'(overflow), longint'(e.ovf));
      end else begin
        chk("hold_sum", longint'(sum), longint'(sb[0].sum));
        chk("hold_valid", longint'(out_valid), 1);
      end
    end
  end

  task automatic start_eval(input int b);
    start = 1'b1;
    bias  = 16'(b);
    @(posedge clk); #1;
    start = 1'b0;
    chk("in_ready_after_start", longint'(in_ready), 1);
    chk("busy_after_start", longint'(busy), 1);
  endtask

  task automatic run_beats(input int b, input int stall_at, input int stall_len);
    sb.push_back(model(b));
    n_push++;
    for (int i = 0; i < N; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          chk("in_ready_stall", longint'(in_ready), 1);
        end
      end
      in_valid = 1'b1;
      x = 16'(bx[i]);
      w = 16'(bw[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("out_valid_latency", longint'(out_valid), 1);
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    chk("idle_busy", longint'(busy), 0);
    chk("idle_out_valid", longint'(out_valid), 0);
  endtask

  task automatic set_beats(input int x0, input int x1, input int x2, input int x3,
                           input int w0, input int w1, input int w2, input int w3);
    bx[0] = x0; bx[1] = x1; bx[2] = x2; bx[3] = x3;
    bw[0] = w0; bw[1] = w1; bw[2] = w2; bw[3] = w3;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; x = '0; w = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sum", longint'(sum), 0);
    chk("rst_ovf", longint'(overflow), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);

    // Basic sum: expect 2.0
    set_beats(ONE, 2*ONE, -ONE, ONE/4, ONE/2, ONE/2, ONE, 4*ONE);
    start_eval(ONE/2);
    run_beats(ONE/2, N, 0);
    chk("basic_sum_direct", longint'(sum), 2*ONE);
    go_idle();

    // Input stall plus 5 cycles of backpressure
    start_eval(ONE/2);
    out_ready = 1'b0;
    run_beats(ONE/2, 2, 3);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_sum", longint'(sum), 2*ONE);
    end
    out_ready = 1'b1;
    go_idle();

    // Saturation both ways
    set_beats(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767);
    start_eval(0);
    run_beats(0, N, 0);
    chk("sat_hi_direct", longint'(sum), 32767);
    go_idle();
    set_beats(32767, 32767, 32767, 32767, -32768, -32768, -32768, -32768);
    start_eval(0);
    run_beats(0, N, 0);
    chk("sat_lo_direct", longint'(sum), -32768);
    go_idle();

    // Rounding toward -inf: -1 LSB * 0.5 = -1 LSB
    set_beats(-1, 0, 0, 0, ONE/2, 0, 0, 0);
    start_eval(0);
    run_beats(0, N, 0);
    chk("round_direct", longint'(sum), -1);

    // Back-to-back: start together with the output handshake
    set_beats(0, 0, 0, 0, 0, 0, 0, 0);
    start_eval(-ONE);
    chk("b2b_out_valid_drop", longint'(out_valid), 0);
    run_beats(-ONE, N, 0);
    chk("b2b_sum_direct", longint'(sum), -ONE);
    go_idle();

    // Reset after two accepted beats discards the evaluation
    set_beats(ONE, ONE, ONE, ONE, ONE, ONE, ONE, ONE);
    start_eval(ONE);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x = 16'(bx[i]); w = 16'(bw[i]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_sum", longint'(sum), 0);
    set_beats(0, 0, 0, 0, 0, 0, 0, 0);
    start_eval(ONE/4);
    run_beats(ONE/4, N, 0);
    chk("post_rst_sum_direct", longint'(sum), ONE/4);
    go_idle();

    // Randomized evaluations with stalls, backpressure and back-to-back starts
    for (int k = 0; k < 30; k++) begin
      int b, bp, sat_case;
      b = int'($urandom_range(0, 4095)) - 2048;
      sat_case = int'($urandom_range(0, 5));
      for (int i = 0; i < N; i++) begin
        if (sat_case == 0) begin
          bx[i] = int'($urandom_range(0, 65535)) - 32768;
          bw[i] = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          bx[i] = int'($urandom_range(0, 2047)) - 1024;
          bw[i] = int'($urandom_range(0, 2047)) - 1024;
        end
      end
      start_eval(b);
      bp = int'($urandom_range(0, 3));
      if (bp > 0) out_ready = 1'b0;
      run_beats(b, int'($urandom_range(0, N)), int'($urandom_range(0, 3)));
      if (bp > 0) begin
        repeat (bp) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) go_idle();
    end
    go_idle();

    chk("scoreboard_empty", longint'(sb.size()), 0);
    chk("result_count", longint'(n_pop), longint'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
